// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM states and
// the oversample sample point.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_POINT = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  // True when the received parity bit disagrees with the configured mode.
  function automatic logic parity_mismatch(input logic data_xor, input logic par_bit,
                                           input int mode);
    return (data_xor ^ par_bit) != (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/baud_rate_generator.sv
// Free-running divider producing a one-cycle tick every BR_LIMIT clocks
// (16x oversample rate).
module baud_rate_generator #(
  parameter int BR_LIMIT = 326,
  parameter int BR_BITS  = 9
) (
  input  logic clk_50MHz,
  input  logic reset,
  output logic tick
);

  localparam logic [BR_BITS-1:0] LAST_COUNT = BR_BITS'(BR_LIMIT - 1);

  logic [BR_BITS-1:0] count_reg;

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (count_reg == LAST_COUNT) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST_COUNT);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with configurable frame format, parity/frame/break detection
// and a single-entry holding register with valid/ready handshake.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int BR_LIMIT    = 326,
  parameter int BR_BITS     = 9
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] START_TICK = 4'(SAMPLE_POINT);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

  logic                 tick;
  logic [1:0]           sync_reg;
  logic                 rx_s;
  logic                 rx_prev_reg;
  rx_state_t            state_reg;
  logic [3:0]           tick_cnt_reg;
  logic [3:0]           bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 all_low_reg;
  logic                 par_fail_reg;
  logic                 frm_fail_reg;
  logic                 done_reg;
  logic                 brk_reg;
  logic                 sample;

  baud_rate_generator #(
    .BR_LIMIT(BR_LIMIT),
    .BR_BITS (BR_BITS)
  ) u_baud (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .tick     (tick)
  );

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= sync_reg[1];
    end
  end

  assign rx_s   = sync_reg[1];
  assign sample = tick && (tick_cnt_reg == LAST_TICK);

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      all_low_reg  <= 1'b0;
      par_fail_reg <= 1'b0;
      frm_fail_reg <= 1'b0;
      done_reg     <= 1'b0;
      brk_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      brk_reg  <= 1'b0;
      // Outside START the 4-bit tick counter wraps 15->0 by itself.
      if (tick && state_reg != IDLE && state_reg != BRK_WAIT)
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (rx_prev_reg && !rx_s) begin
            state_reg    <= START;
            tick_cnt_reg <= '0;
          end
        end
        START: begin
          if (tick && tick_cnt_reg == START_TICK) begin
            tick_cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= IDLE;
            end else begin
              state_reg    <= DATA;
              bit_cnt_reg  <= '0;
              all_low_reg  <= 1'b1;
              par_fail_reg <= 1'b0;
              frm_fail_reg <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift_reg   <= {rx_s, shift_reg[DATA_BITS-1:1]};
            all_low_reg <= all_low_reg & ~rx_s;
            if (bit_cnt_reg == LAST_DATA) begin
              bit_cnt_reg <= '0;
              state_reg   <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample) begin
            par_fail_reg <= parity_mismatch(^shift_reg, rx_s, PARITY_MODE);
            all_low_reg  <= all_low_reg & ~rx_s;
            state_reg    <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            // A low first stop bit after an all-low frame is a break, not a word.
            if (bit_cnt_reg == '0 && all_low_reg && !rx_s) begin
              brk_reg   <= 1'b1;
              state_reg <= BRK_WAIT;
            end else begin
              frm_fail_reg <= frm_fail_reg | ~rx_s;
              if (bit_cnt_reg == LAST_STOP) begin
                done_reg  <= 1'b1;
                state_reg <= IDLE;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
        end
        BRK_WAIT: begin
          if (rx_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= done_reg & par_fail_reg;
      frame_err  <= done_reg & frm_fail_reg;
      break_det  <= brk_reg;
      overrun    <= done_reg & rx_valid & ~rx_ready;
      if (done_reg && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three frame formats driven with directed and random
// frames, outcomes predicted by a frame-level model.
module tb_uart_rx_ext;

  localparam int BRL = 4;
  localparam int BIT = 16 * BRL;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] ready = 3'b111;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic [8:0] rd [3];
  logic [2:0] rv, pe, fe, bd, ov;
  logic [2:0] rv_d = 3'b000;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_valid [3] = '{0, 0, 0};
  int n_acc   [3] = '{0, 0, 0};
  int n_pe    [3] = '{0, 0, 0};
  int n_fe    [3] = '{0, 0, 0};
  int n_bd    [3] = '{0, 0, 0};
  int n_ov    [3] = '{0, 0, 0};
  int rise_cyc[3] = '{0, 0, 0};
  logic [8:0] last_acc [3];

  always #10 clk = ~clk;

  uart_rx_ext #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .BR_LIMIT(BRL), .BR_BITS(3)) dut_a (
    .clk_50MHz(clk), .reset(reset), .rx(rx_line[0]), .rx_data(data_a), .rx_valid(rv[0]),
    .rx_ready(ready[0]), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]), .overrun(ov[0]));
  uart_rx_ext #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .BR_LIMIT(BRL), .BR_BITS(3)) dut_b (
    .clk_50MHz(clk), .reset(reset), .rx(rx_line[1]), .rx_data(data_b), .rx_valid(rv[1]),
    .rx_ready(ready[1]), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]), .overrun(ov[1]));
  uart_rx_ext #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .BR_LIMIT(BRL), .BR_BITS(3)) dut_c (
    .clk_50MHz(clk), .reset(reset), .rx(rx_line[2]), .rx_data(data_c), .rx_valid(rv[2]),
    .rx_ready(ready[2]), .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]), .overrun(ov[2]));

  assign rd[0] = {1'b0, data_a};
  assign rd[1] = {1'b0, data_b};
  assign rd[2] = {2'b00, data_c};

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rv[i]) n_valid[i]++;
      if (rv[i] && !rv_d[i]) rise_cyc[i] = cyc;
      if (rv[i] && ready[i]) begin
        n_acc[i]++;
        last_acc[i] = rd[i];
      end
      if (pe[i]) n_pe[i]++;
      if (fe[i]) n_fe[i]++;
      if (bd[i]) n_bd[i]++;
      if (ov[i]) n_ov[i]++;
    end
    rv_d = rv;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int db_of(input int idx);
    return (idx == 2) ? 7 : 8;
  endfunction

  function automatic int sb_of(input int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  function automatic int cnt(input int idx, input int k);
    case (k)
      0:       return n_valid[idx];
      1:       return n_acc[idx];
      2:       return n_pe[idx];
      3:       return n_fe[idx];
      4:       return n_bd[idx];
      default: return n_ov[idx];
    endcase
  endfunction

  // Sender's parity bit: makes the total ones count even (mode 1) or odd (mode 2), optionally inverted.
  function automatic logic par_bit(input int idx, input logic [8:0] d, input logic flip);
    int ones;
    ones = $countones(d);
    return ((idx == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1)) ^ flip;
  endfunction

  function automatic logic [15:0] make_bits(input int idx, input logic [8:0] d, input logic flip,
                                            input logic [1:0] stop_low, output int n);
    logic [15:0] bits;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < db_of(idx); k++) begin
      bits[n] = d[k]; n++;
    end
    if (idx != 0) begin
      bits[n] = par_bit(idx, d, flip); n++;
    end
    bits[n] = ~stop_low[0]; n++;
    if (sb_of(idx) == 2) begin
      bits[n] = ~stop_low[1]; n++;
    end
    return bits;
  endfunction

  task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_line[idx] = bits[i];
      repeat (BIT) @(negedge clk);
    end
    rx_line[idx] = 1'b1;
  endtask

  task automatic snap(input int idx, output int b[6]);
    for (int k = 0; k < 6; k++) b[k] = cnt(idx, k);
  endtask

  task automatic check_counts(input string tag, input int idx, input int b[6], input int e_valid,
                              input int e_acc, input int e_pe, input int e_fe, input int e_bd,
                              input int e_ov);
    check({tag, "/valid_cycles"}, cnt(idx, 0) - b[0], e_valid);
    check({tag, "/accepts"},      cnt(idx, 1) - b[1], e_acc);
    check({tag, "/parity_err"},   cnt(idx, 2) - b[2], e_pe);
    check({tag, "/frame_err"},    cnt(idx, 3) - b[3], e_fe);
    check({tag, "/break_det"},    cnt(idx, 4) - b[4], e_bd);
    check({tag, "/overrun"},      cnt(idx, 5) - b[5], e_ov);
  endtask

  // Sends one frame with rx_ready high and checks it against the frame-level model.
  task automatic run_frame(input int idx, input logic [8:0] d_in, input logic flip,
                           input logic [1:0] stop_low, input string tag);
    logic [8:0]  d;
    logic [15:0] bits;
    logic        pbit, s0, s1, brk, e_pe, e_fe;
    int          n, start, lat, ones;
    int          b[6];
    d    = d_in & ((9'd1 << db_of(idx)) - 9'd1);
    ones = $countones(d);
    pbit = par_bit(idx, d, flip);
    s0   = ~stop_low[0];
    s1   = (sb_of(idx) == 2) ? ~stop_low[1] : 1'b1;
    brk  = (d == '0) && (idx == 0 || !pbit) && !s0;
    e_pe = !brk && (idx != 0) && (((ones + int'(pbit)) % 2) != ((idx == 2) ? 1 : 0));
    e_fe = !brk && (!s0 || !s1);
    bits = make_bits(idx, d, flip, stop_low, n);
    snap(idx, b);
    @(negedge clk);
    start = cyc;
    send_bits(idx, bits, n);
    repeat (2 * BIT) @(negedge clk);
    lat = rise_cyc[idx] - start;
    $display("frame %s inst=%0d data=0x%0h load=%0d pe=%0d fe=%0d brk=%0d", tag, idx, d,
             !brk, e_pe, e_fe, brk);
    check_counts(tag, idx, b, brk ? 0 : 1, brk ? 0 : 1, int'(e_pe), int'(e_fe), int'(brk), 0);
    if (!brk) begin
      check({tag, "/data"}, last_acc[idx], d);
      check({tag, "/latency_ok"}, (lat >= (n - 1) * BIT + BIT / 4) && (lat <= (n - 1) * BIT + 3 * BIT / 4), 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int          n;
    int          b[6];
    logic [1:0]  sl;

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d/rx_valid", i), rv[i], 0);
      check($sformatf("reset%0d/rx_data", i), rd[i], 0);
      check($sformatf("reset%0d/flags", i), {pe[i], fe[i], bd[i], ov[i]}, 0);
    end
    reset = 1'b1;
    repeat (BIT) @(negedge clk);

    run_frame(0, 9'h31, 1'b0, 2'b00, "a_0x31");
    run_frame(1, 9'h33, 1'b1, 2'b00, "b_par_bit1");
    run_frame(1, 9'h33, 1'b0, 2'b00, "b_par_bit0");
    run_frame(0, 9'h32, 1'b0, 2'b01, "a_stop_low");

    snap(0, b);
    rx_line[0] = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    $display("break inst=0 held low 12 bit times");
    check_counts("a_break", 0, b, 0, 0, 0, 0, 1, 0);
    run_frame(0, 9'h31, 1'b0, 2'b00, "a_after_break");

    @(posedge clk); #2 ready[0] = 1'b0;
    snap(0, b);
    bits = make_bits(0, 9'h31, 1'b0, 2'b00, n);
    send_bits(0, bits, n);
    repeat (2 * BIT) @(negedge clk);
    bits = make_bits(0, 9'h32, 1'b0, 2'b00, n);
    send_bits(0, bits, n);
    repeat (2 * BIT) @(negedge clk);
    $display("overrun inst=0 0x31 then 0x32 with rx_ready low");
    check("ovr/rx_valid_held", rv[0], 1);
    check("ovr/rx_data_kept", rd[0], 9'h031);
    check("ovr/overrun_pulses", cnt(0, 5) - b[5], 1);
    @(posedge clk); #2 ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr/drain_accepts", cnt(0, 1) - b[1], 1);
    check("ovr/drain_data", last_acc[0], 9'h031);
    check("ovr/rx_valid_cleared", rv[0], 0);

    snap(0, b);
    @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    $display("glitch inst=0 low for 16 cycles");
    check_counts("a_glitch", 0, b, 0, 0, 0, 0, 0, 0);

    snap(0, b);
    @(negedge clk);
    bits = make_bits(0, 9'h33, 1'b0, 2'b00, n);
    send_bits(0, bits, 4);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    $display("reset mid-frame inst=0");
    check_counts("a_reset_abort", 0, b, 0, 0, 0, 0, 0, 0);
    run_frame(0, 9'h33, 1'b0, 2'b00, "a_after_reset");

    run_frame(2, 9'h55, 1'b0, 2'b00, "c_0x55");

    for (int i = 0; i < 3; i++) begin
      for (int f = 0; f < 8; f++) begin
        sl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        run_frame(i, ($urandom_range(0, 5) == 0) ? 9'h000 : 9'($urandom),
                  ($urandom_range(0, 3) == 0), sl, $sformatf("rnd%0d_%0d", i, f));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, legal 5..9.
REQ-002 Parameter PARITY_MODE, default 0, parity type: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits, legal 1..2.
REQ-004 Parameter BR_LIMIT, default 326, clk_50MHz cycles per 16x oversample tick.
REQ-005 Parameter BR_BITS, default 9, width of the tick divider counter.
REQ-006 clk_50MHz  input  1  single clock for the whole block.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 rx  input  1  asynchronous serial line; idles high.
REQ-009 rx_data  output  DATA_BITS  received data word, LSB received first.
REQ-010 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-011 rx_ready  input  1  consumer accepts the word when rx_valid and rx_ready are both high.
REQ-012 parity_err  output  1  one-cycle pulse: parity mismatch on the last frame.
REQ-013 frame_err  output  1  one-cycle pulse: a stop bit was sampled low.
REQ-014 break_det  output  1  one-cycle pulse: break condition detected.
REQ-015 overrun  output  1  one-cycle pulse: a frame completed while the holding register was full.

Function
REQ-016 The rx input SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 The tick divider SHALL count 0..BR_LIMIT-1 and assert a one-cycle tick at the wrap; it runs continuously.
REQ-018 The FSM SHALL use the states IDLE, START, DATA, PARITY, STOP and BRK_WAIT.
REQ-019 IDLE→START: on a synchronized rx falling edge; the tick counter resets to 0.
REQ-020 START: at tick 7, rx low→DATA with tick counter 0; rx high→IDLE (glitch rejected, no flags).
REQ-021 DATA: sample at every 16th tick, shift in LSB-first, DATA_BITS samples, then go to PARITY (PARITY_MODE≠0) or STOP.
REQ-022 PARITY: sample one bit; even mode requires XOR(data,parity)=0, odd mode requires 1; a mismatch sets the pending parity flag.
REQ-023 STOP: sample STOP_BITS bits; any low sample sets the pending frame flag.
REQ-024 Break: all data bits, the parity bit (if present) and the first stop bit sampled low → pulse break_det only (no frame_err, no parity_err, no data load), then BRK_WAIT.
REQ-025 BRK_WAIT: wait for synchronized rx high, then IDLE.
REQ-026 Frame completion (non-break): in the cycle after the last stop sample, load rx_data, set rx_valid, pulse the pending error flags, return to IDLE.
REQ-027 Errored frames SHALL still be delivered; the error pulses coincide with the load cycle.
REQ-028 Handshake: rx_valid&rx_ready clears rx_valid next cycle, unless a load occurs in the same cycle.
REQ-029 Simultaneous load and accept: the new word is loaded, rx_valid stays 1, no overrun.
REQ-030 Load while rx_valid=1 and rx_ready=0: the old rx_data is kept, the new word is dropped, overrun pulses for 1 cycle.
REQ-031 Latency: rx_valid rises 1 clk_50MHz cycle after the final stop-bit sample.
REQ-032 rx_data SHALL be stable while rx_valid=1 and no accept has occurred.

Reset
REQ-033 While reset=0 at a clk_50MHz edge: FSM→IDLE, counters 0, synchronizer flops 1, rx_data 0, all outputs 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no flag pulse; the first frame after release is received normally.

Structure
REQ-035 PARITY_MODE encodings, the FSM state encodings and the sample point (7) SHALL live in a shared package uart_pkg.
REQ-036 The tick divider SHALL be a single sub-module instance of baud_rate_generator; everything else is in uart_rx_ext.

Verification
REQ-037 Default parameters, 0x31 sent at 9600 baud, rx_ready=1 → rx_data=0x31, one-cycle rx_valid, no flags.
REQ-038 PARITY_MODE=1, 0x33 sent with parity bit 1 → rx_data=0x33 with parity_err pulse; with parity bit 0 → no flag.
REQ-039 0x32 with stop bit low → rx_data=0x32, frame_err pulse; then rx held low ≥12 bit times → break_det once, recovery after rx high.
REQ-040 rx_ready=0, 0x31 then 0x32 sent → rx_data remains 0x31, overrun pulse at the second frame end.
REQ-041 A 3 µs low glitch on rx → no rx_valid and no flags; reset asserted mid-byte → clean receipt of the next 0x33.
REQ-042 DATA_BITS=7, STOP_BITS=2, PARITY_MODE=2, 0x55 sent → rx_data=0x55, no flags.
